// File: rtl/mul_issue_arbiter.sv
// Round-robin issue arbiter sharing one pipelined multiplier between two requesters.
// Tracks in-flight ops to steer results home and to stall self-dependent requests.
module mul_issue_arbiter #(
  parameter int LATENCY = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [9:0] req_rd,
  input  logic [9:0] req_rs1,
  input  logic [9:0] req_rs2,
  input  logic [3:0] req_mul_control,
  input  logic [1:0] flush,
  output logic       mul_issue_valid,
  output logic       mul_issue_sel,
  output logic [1:0] mul_issue_control,
  output logic [4:0] mul_issue_rd,
  input  logic       mul_wb_valid,
  output logic [1:0] result_valid,
  output logic [4:0] result_rd,
  output logic       busy
);

  localparam int DEPTH = LATENCY + 1;

  typedef struct packed {
    logic       valid;
    logic       owner;
    logic [4:0] rd;
  } trk_t;

  trk_t       trk [DEPTH];
  trk_t       tail;
  logic       ptr;
  logic [1:0] hazard;
  logic [1:0] eligible;
  logic [1:0] grant;
  logic       grant_idx;
  logic [4:0] grant_rd;
  logic [1:0] grant_ctl;

  // A requester only waits on its own producers; every stage up to and
  // including the result cycle still counts as unwritten.
  always_comb begin
    hazard = '0;
    for (int k = 0; k < DEPTH; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (trk[k].valid && trk[k].owner == 1'(i) &&
            ((req_rs1[i*5 +: 5] != 5'd0 && req_rs1[i*5 +: 5] == trk[k].rd) ||
             (req_rs2[i*5 +: 5] != 5'd0 && req_rs2[i*5 +: 5] == trk[k].rd)))
          hazard[i] = 1'b1;
      end
    end
  end

  assign eligible = req_valid & ~flush & ~hazard & {2{~rst}};

  always_comb begin
    // NOTE: assign every always_comb output up front so no path can infer a latch.
    grant = eligible;
    if (&eligible) grant = ptr ? 2'b10 : 2'b01;
  end

  assign grant_idx = grant[1];
  assign grant_rd  = grant_idx ? req_rd[9:5]          : req_rd[4:0];
  assign grant_ctl = grant_idx ? req_mul_control[3:2] : req_mul_control[1:0];
  assign req_ready = grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr               <= 1'b0;
      mul_issue_valid   <= 1'b0;
      mul_issue_sel     <= 1'b0;
      mul_issue_control <= 2'b00;
      mul_issue_rd      <= 5'd0;
      // NOTE: the tracker is a short shift register, so every stage is reset;
      // large storage arrays would normally clear only their valid bits.
      for (int k = 0; k < DEPTH; k++) trk[k] <= '0;
    end else begin
      mul_issue_valid <= |grant;
      if (|grant) begin
        ptr               <= ~grant_idx;
        mul_issue_sel     <= grant_idx;
        mul_issue_control <= grant_ctl;
        mul_issue_rd      <= grant_rd;
      end
      trk[0] <= '{valid: |grant, owner: grant_idx, rd: grant_rd};
      // Flush squashes the owner's entries as they shift, dropping their results.
      for (int k = 1; k < DEPTH; k++) begin
        trk[k]       <= trk[k-1];
        trk[k].valid <= trk[k-1].valid && !flush[trk[k-1].owner];
      end
    end
  end

  assign tail = trk[LATENCY];

  always_comb begin
    result_valid = 2'b00;
    if (!rst && tail.valid && mul_wb_valid)
      result_valid = tail.owner ? 2'b10 : 2'b01;
  end

  assign result_rd = rst ? 5'd0 : tail.rd;

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < DEPTH; k++) busy = busy | trk[k].valid;
  end

  // A live op reaching its result cycle must coincide with the multiplier writeback.
  a_wb_missing: assert property (@(posedge clk) disable iff (rst) tail.valid |-> mul_wb_valid);

endmodule

// File: tb/tb_mul_issue_arbiter.sv
// Directed bench for mul_issue_arbiter; a delay-line multiplier model returns
// mul_wb_valid LATENCY cycles after each issue strobe.
module tb_mul_issue_arbiter;

  localparam int LAT = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid, req_ready, flush, result_valid;
  logic [9:0] req_rd, req_rs1, req_rs2;
  logic [3:0] req_mul_control;
  logic       mul_issue_valid, mul_issue_sel, mul_wb_valid, busy;
  logic [1:0] mul_issue_control;
  logic [4:0] mul_issue_rd, result_rd;
  logic [LAT-1:0] wb_line = '0;

  int vectors = 0;
  int miscompares = 0;

  mul_issue_arbiter #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_mul_control(req_mul_control), .flush(flush),
    .mul_issue_valid(mul_issue_valid), .mul_issue_sel(mul_issue_sel),
    .mul_issue_control(mul_issue_control), .mul_issue_rd(mul_issue_rd),
    .mul_wb_valid(mul_wb_valid), .result_valid(result_valid),
    .result_rd(result_rd), .busy(busy)
  );

  always #5 clk = ~clk;

  // Multiplier model: writeback LAT cycles after the issue strobe.
  always @(posedge clk) wb_line <= {wb_line[LAT-2:0], mul_issue_valid === 1'b1};
  assign mul_wb_valid = wb_line[LAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 2'b00; flush = 2'b00;
    req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_mul_control = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; idle(); tick(); tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); req_valid = 2'b01;
    @(negedge clk);
    vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL reset_ready: got %b want 00", req_ready); end
    vectors++; if (result_valid !== 2'b00) begin miscompares++; $display("FAIL reset_result: got %b want 00", result_valid); end
    tick();
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if ({mul_issue_valid, mul_issue_sel, mul_issue_control, mul_issue_rd} !== 9'd0) begin
      miscompares++; $display("FAIL reset_issue: got %b/%b/%b/%0d want all 0", mul_issue_valid, mul_issue_sel, mul_issue_control, mul_issue_rd); end
    vectors++; if (result_rd !== 5'd0) begin miscompares++; $display("FAIL reset_result_rd: got %0d want 0", result_rd); end
    tick(); rst = 1'b0; idle();
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 2'b01; req_rd = {5'd0, 5'd5}; req_mul_control = {2'b00, 2'b01};
    @(negedge clk);
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL single_ready: got %b want 01", req_ready); end
    tick(); idle();
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) begin
        vectors++; if (!(mul_issue_valid === 1'b1 && mul_issue_sel === 1'b0 && mul_issue_rd === 5'd5 && mul_issue_control === 2'b01)) begin
          miscompares++; $display("FAIL single_issue: got v=%b sel=%b rd=%0d ctl=%b want v=1 sel=0 rd=5 ctl=01", mul_issue_valid, mul_issue_sel, mul_issue_rd, mul_issue_control); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b want 1", busy); end
      end
      if (k == 2) begin
        vectors++; if (mul_issue_valid !== 1'b0 || mul_issue_rd !== 5'd5) begin
          miscompares++; $display("FAIL single_issue_hold: got v=%b rd=%0d want v=0 rd=5", mul_issue_valid, mul_issue_rd); end
      end
      if (k == 5 || k == 7) begin
        vectors++; if (result_valid !== 2'b00) begin miscompares++; $display("FAIL single_no_result_k%0d: got %b want 00", k, result_valid); end
      end
      if (k == 6) begin
        vectors++; if (result_valid !== 2'b01 || result_rd !== 5'd5) begin
          miscompares++; $display("FAIL single_result: got %b rd=%0d want 01 rd=5", result_valid, result_rd); end
      end
      if (k == 7) begin
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_idle: got busy=%b want 0", busy); end
      end
      tick();
    end
  endtask

  task automatic test_contention();
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      req_valid = (c < 4) ? 2'b11 : 2'b00;
      req_rd = {5'(c + 17), 5'(c + 1)};
      req_mul_control = {2'b11, 2'b10};
      @(negedge clk);
      if (c < 4) begin
        logic [1:0] exp_g;
        exp_g = (c % 2 == 1) ? 2'b10 : 2'b01;
        vectors++; if (req_ready !== exp_g) begin miscompares++; $display("FAIL contention_grant_c%0d: got %b want %b", c, req_ready, exp_g); end
      end
      if (c >= 1 && c <= 4) begin
        int g;
        logic       e_sel;
        logic [4:0] e_rd;
        logic [1:0] e_ctl;
        g = c - 1;
        e_sel = (g % 2 == 1);
        e_rd  = e_sel ? 5'(g + 17) : 5'(g + 1);
        e_ctl = e_sel ? 2'b11 : 2'b10;
        vectors++; if (!(mul_issue_valid === 1'b1 && mul_issue_sel === e_sel && mul_issue_rd === e_rd && mul_issue_control === e_ctl)) begin
          miscompares++; $display("FAIL contention_issue_c%0d: got v=%b sel=%b rd=%0d ctl=%b want v=1 sel=%b rd=%0d ctl=%b",
                                  c, mul_issue_valid, mul_issue_sel, mul_issue_rd, mul_issue_control, e_sel, e_rd, e_ctl); end
      end
      if (c >= 6 && c <= 9) begin
        int g;
        logic [1:0] e_res;
        logic [4:0] e_rd;
        g = c - 6;
        e_res = (g % 2 == 1) ? 2'b10 : 2'b01;
        e_rd  = (g % 2 == 1) ? 5'(g + 17) : 5'(g + 1);
        vectors++; if (result_valid !== e_res || result_rd !== e_rd) begin
          miscompares++; $display("FAIL contention_result_c%0d: got %b rd=%0d want %b rd=%0d", c, result_valid, result_rd, e_res, e_rd); end
      end
      if (c == 10) begin
        vectors++; if (result_valid !== 2'b00) begin miscompares++; $display("FAIL contention_tail_empty: got %b want 00", result_valid); end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_hazard();
    do_reset();
    for (int c = 0; c <= 7; c++) begin
      logic [1:0] exp_g;
      if (c == 0) begin
        req_valid = 2'b01; req_rd = {5'd0, 5'd7};
        exp_g = 2'b01;
      end else begin
        req_valid = (c == 1) ? 2'b11 : 2'b01;
        req_rd  = {5'd9, 5'd8};
        req_rs1 = {5'd0, 5'd7};
        req_rs2 = {5'd7, 5'd0};
        exp_g = (c == 1) ? 2'b10 : (c == 7) ? 2'b01 : 2'b00;
      end
      @(negedge clk);
      vectors++; if (req_ready !== exp_g) begin miscompares++; $display("FAIL hazard_ready_t+%0d: got %b want %b", c, req_ready, exp_g); end
      tick();
    end
    idle();
  endtask

  task automatic test_x0();
    do_reset();
    req_valid = 2'b01; req_rd = {5'd0, 5'd0};
    @(negedge clk);
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL x0_first: got %b want 01", req_ready); end
    tick();
    req_rd = {5'd0, 5'd3}; req_rs1 = '0; req_rs2 = '0;
    @(negedge clk);
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL x0_no_stall: got %b want 01", req_ready); end
    tick();
    req_rd = {5'd0, 5'd4}; req_rs2 = {5'd0, 5'd3};
    @(negedge clk);
    vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL x0_rs2_stall: got %b want 00", req_ready); end
    tick(); idle();
  endtask

  task automatic test_flush();
    do_reset();
    req_valid = 2'b10; req_rd = {5'd11, 5'd0};
    @(negedge clk);
    vectors++; if (req_ready !== 2'b10) begin miscompares++; $display("FAIL flush_grant0: got %b want 10", req_ready); end
    tick();
    req_rd = {5'd12, 5'd0};
    @(negedge clk);
    vectors++; if (req_ready !== 2'b10) begin miscompares++; $display("FAIL flush_grant1: got %b want 10", req_ready); end
    tick();
    req_valid = 2'b11; req_rd = {5'd14, 5'd13}; flush = 2'b10;
    @(negedge clk);
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL flush_block: got %b want 01", req_ready); end
    vectors++; if (!(mul_issue_valid === 1'b1 && mul_issue_sel === 1'b1 && mul_issue_rd === 5'd12)) begin
      miscompares++; $display("FAIL flush_issue_kept: got v=%b sel=%b rd=%0d want v=1 sel=1 rd=12", mul_issue_valid, mul_issue_sel, mul_issue_rd); end
    tick(); idle();
    for (int c = 3; c <= 9; c++) begin
      @(negedge clk);
      if (c == 3) begin
        vectors++; if (mul_issue_sel !== 1'b0 || mul_issue_rd !== 5'd13 || busy !== 1'b1) begin
          miscompares++; $display("FAIL flush_req0_issue: got sel=%b rd=%0d busy=%b want sel=0 rd=13 busy=1", mul_issue_sel, mul_issue_rd, busy); end
      end
      if (c == 6 || c == 7) begin
        vectors++; if (result_valid !== 2'b00) begin miscompares++; $display("FAIL flush_dropped_t+%0d: got %b want 00", c, result_valid); end
      end
      if (c == 8) begin
        vectors++; if (result_valid !== 2'b01 || result_rd !== 5'd13) begin
          miscompares++; $display("FAIL flush_req0_result: got %b rd=%0d want 01 rd=13", result_valid, result_rd); end
      end
      if (c == 9) begin
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL flush_idle: got busy=%b want 0", busy); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 2'b01; req_rd = {5'd0, 5'd1}; tick();
    req_valid = 2'b10; req_rd = {5'd2, 5'd0}; tick();
    req_valid = 2'b01; req_rd = {5'd0, 5'd3}; tick();
    rst = 1'b1; req_valid = 2'b01;
    @(negedge clk);
    vectors++; if (req_ready !== 2'b00 || busy !== 1'b1) begin
      miscompares++; $display("FAIL rstmid_during: got ready=%b busy=%b want ready=00 busy=1", req_ready, busy); end
    tick();
    rst = 1'b0; req_valid = 2'b11; req_rd = {5'd20, 5'd21};
    @(negedge clk);
    vectors++; if ({busy, mul_issue_valid, mul_issue_sel, mul_issue_control, mul_issue_rd, result_valid} !== 12'd0) begin
      miscompares++; $display("FAIL rstmid_cleared: got busy=%b v=%b sel=%b ctl=%b rd=%0d res=%b want all 0",
                              busy, mul_issue_valid, mul_issue_sel, mul_issue_control, mul_issue_rd, result_valid); end
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL rstmid_ptr: got %b want 01", req_ready); end
    tick(); idle();
    for (int c = 5; c <= 10; c++) begin
      @(negedge clk);
      if (c < 10) begin
        vectors++; if (result_valid !== 2'b00) begin miscompares++; $display("FAIL rstmid_discard_t+%0d: got %b want 00", c, result_valid); end
      end else begin
        vectors++; if (result_valid !== 2'b01 || result_rd !== 5'd21) begin
          miscompares++; $display("FAIL rstmid_new_result: got %b rd=%0d want 01 rd=21", result_valid, result_rd); end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_hazard();
    test_x0();
    test_flush();
    test_reset_mid();
    repeat (8) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mul_issue_arbiter.md
Name: mul_issue_arbiter

Overview:
Shares the single pipelined integer multiplier between two issue requesters (req 0 = scalar pipe, req 1 = secondary issue slot). It round-robin arbitrates one MUL per cycle and drives the multiplier's issue fields (registered). It tracks every in-flight op (owner, rd) through the fixed multiplier latency, so results are steered back to the correct requester. It also stalls a requester whose source registers depend on one of its own in-flight MUL destinations.

Parameters:
LATENCY, 5, cycles from mul_issue_valid high to the matching mul_wb_valid high (multiplier pipe plus output register); legal range 2..8.

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
req_valid  in  2  per-requester MUL request
req_ready  out  2  per-requester grant; a transfer occurs when valid && ready
req_rd  in  10  {rd1, rd0}, 5 bits each
req_rs1  in  10  {rs1_1, rs1_0}
req_rs2  in  10  {rs2_1, rs2_0}
req_mul_control  in  4  {ctl1, ctl0}: MUL_OP_MUL/MULH/MULHSU/MULHU encoding
flush  in  2  per-requester squash of that requester's in-flight ops
mul_issue_valid  out  1  registered issue strobe to the multiplier
mul_issue_sel  out  1  operand-mux select (owner of the issued op)
mul_issue_control  out  2  registered mul_control of the issued op
mul_issue_rd  out  5  registered rd of the issued op
mul_wb_valid  in  1  result-valid from the multiplier's writeback stage
result_valid  out  2  one-hot: result belongs to requester i
result_rd  out  5  rd of the returning result
busy  out  1  any in-flight entry valid

Behaviour:
- Reset: all outputs 0; tracker emptied; priority pointer = 0 (req 0 favoured first).
- Eligibility of requester i:
  - req_valid[i] && !flush[i], and
  - no hazard. A hazard exists when rs1_i or rs2_i is nonzero and equals the rd of any valid tracker entry owned by i, including the entry in its result cycle.
  - rs == 0 never causes a hazard.
  - Cross-requester dependencies are not checked.
- Arbitration, combinational within a cycle:
  - Only one requester eligible: grant it.
  - Both eligible: grant the pointer's requester.
  - Pointer moves to the non-granted requester after every grant; it is unchanged when there is no grant.
- req_ready[i] = grant[i]. It is never high without req_valid[i], and at most one bit is high.
- Issue stage, registered, one cycle after the grant:
  - mul_issue_valid = any grant.
  - mul_issue_sel = granted index.
  - mul_issue_control and mul_issue_rd come from the granted requester.
  - With no grant, mul_issue_valid = 0 and the other issue fields hold.
- Tracker: a LATENCY+1 stage shift register of {valid, owner, rd}.
  - The entry enters at the grant cycle t and reaches the tail at t+1+LATENCY, which is the mul_wb_valid cycle.
  - At the tail: result_valid[owner] = tail.valid && mul_wb_valid, and result_rd = tail.rd. Both are combinational off the tail.
  - mul_wb_valid high with tail invalid (a flushed op) produces no result_valid.
  - Tail valid with mul_wb_valid low is an error; flag it with a simulation assertion only.
- Flush:
  - flush[i] clears the valid bit of every tracker entry owned by i at the next clock edge.
  - It blocks any grant to i in the same cycle.
  - It does not cancel an issue already registered in mul_issue_*. That op's tracker entry is cleared, so its result is dropped.
  - flush = 2'b11 empties the tracker.
- Hazard release: a stalled requester becomes eligible the cycle after the producer's result cycle. This is when the register file write is visible.
- busy = OR of all tracker valid bits.
- Throughput: one grant per cycle sustained when hazards allow.
- Reset mid-operation: the tracker is cleared, pending results are discarded, and the pointer returns to 0.

Test Plan:
- Single op: req0 MUL rd=5 at cycle 10, LATENCY=5 -> req_ready=01 at 10; mul_issue_valid, sel=0, rd=5 at 11; with mul_wb_valid at 16 -> result_valid=01, result_rd=5 at 16; busy low at 17.
- Contention: both requesters valid, hazard-free, for 4 cycles from reset -> grants 0,1,0,1; mul_issue_sel sequence 0,1,0,1 one cycle later; results return in the same order.
- Hazard: req0 issues rd=7 at t; req0 next requests rs1=7 -> req_ready[0]=0 through t+6, granted at t+7; req1 with rs2=7 is granted at t+1.
- x0 source: in-flight rd=0 op, then request rs1=0 -> no stall, granted the next cycle.
- Flush: req1 ops issued at t and t+1, flush=10 at t+2 -> no result_valid[1] at t+6 or t+7 despite mul_wb_valid; req0 traffic unaffected.
- Reset mid-operation: 3 ops in flight, rst high one cycle -> all outputs 0, busy=0; the following mul_wb_valid pulses give no result_valid; the first grant after reset goes to req0.
